// File: rtl/rom_chip_burner.sv
// rtl/rom_chip_burner.sv - bit-serial bipolar PROM fuse programmer with read-back verify after every pulse
// Optional feature macro: ROM_CHIP_BURNER_OVERPROGRAM_EN (adds a lengthened overpulse once a bit verifies)
module rom_chip_burner #(
  parameter int SETUP_CYCLES    = 4,
  parameter int READ_CYCLES     = 3,
  parameter int VPP_RISE_CYCLES = 8,
  parameter int PULSE_CYCLES    = 16,
  parameter int RECOVER_CYCLES  = 8,
  parameter int MAX_ATTEMPTS    = 8
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       start,
  input  logic [8:0] target_address,
  input  logic [7:0] target_data,
  input  logic [7:0] chip_data_port,
  output logic [8:0] chip_address_port,
  output logic       chip_select,
  output logic       vpp_enable,
  output logic [7:0] program_bit_port,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] error_code,
  output logic [2:0] failed_bit,
  output logic [7:0] read_value
);
  localparam int CW = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_VPP_ON,
    S_PULSE,
    S_RECOVER,
    S_DONE,
    S_ERROR
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
    , S_OVP_RISE,
    S_OVP_PULSE
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_reload;
  logic [8:0]    r_addr;
  logic [7:0]    r_target;
  logic [7:0]    r_read_value;
  logic [2:0]    r_sel;
  logic [3:0]    r_attempts;
  logic          r_error;
  logic [1:0]    r_error_code;
  logic [2:0]    r_failed_bit;
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
  logic          r_verify_pending;
`endif

  logic          w_last;
  logic          w_eval;
  logic [7:0]    w_bad;
  logic [7:0]    w_pending;
  logic [2:0]    w_bad_idx;
  logic [2:0]    w_sel;
  logic [3:0]    w_attempts_eff;
  logic          w_err_set;
  logic [1:0]    w_err_code;
  logic [2:0]    w_err_bit;
  logic          w_active;
  logic          w_pulsing;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  assign w_last         = (r_cnt == '0);
  assign w_eval         = (r_state == S_READ) && w_last;
  assign w_bad          = chip_data_port & ~r_target;
  assign w_pending      = r_target & ~chip_data_port;
  assign w_bad_idx      = lowest_set(w_bad);
  assign w_sel          = lowest_set(w_pending);
  // A new bit starts with a fresh attempt budget
  assign w_attempts_eff = (w_sel != r_sel) ? 4'd0 : r_attempts;

  always_comb begin
    w_next     = r_state;
    w_err_set  = 1'b0;
    w_err_code = 2'd0;
    w_err_bit  = 3'd0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_SETUP;
      S_SETUP:   if (w_last) w_next = S_READ;
      S_READ: begin
        if (w_last) begin
          if (w_bad != 8'd0) begin
            w_next     = S_ERROR;
            w_err_set  = 1'b1;
            w_err_code = 2'd1;
            w_err_bit  = w_bad_idx;
          end
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
          else if (r_verify_pending && chip_data_port[r_sel]) begin
            w_next = S_OVP_RISE;
          end
`endif
          else if (w_pending == 8'd0) begin
            w_next = S_DONE;
          end else if (w_attempts_eff == 4'(MAX_ATTEMPTS)) begin
            w_next     = S_ERROR;
            w_err_set  = 1'b1;
            w_err_code = 2'd2;
            w_err_bit  = w_sel;
          end else begin
            w_next = S_VPP_ON;
          end
        end
      end
      S_VPP_ON:  if (w_last) w_next = S_PULSE;
      S_PULSE:   if (w_last) w_next = S_RECOVER;
      S_RECOVER: if (w_last) w_next = S_READ;
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
      S_OVP_RISE:  if (w_last) w_next = S_OVP_PULSE;
      S_OVP_PULSE: if (w_last) w_next = S_RECOVER;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_reload = '0;
    case (w_next)
      S_SETUP:     w_reload = CW'(SETUP_CYCLES - 1);
      S_READ:      w_reload = CW'(READ_CYCLES - 1);
      S_VPP_ON:    w_reload = CW'(VPP_RISE_CYCLES - 1);
      S_PULSE:     w_reload = CW'(PULSE_CYCLES - 1);
      S_RECOVER:   w_reload = CW'(RECOVER_CYCLES - 1);
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
      S_OVP_RISE:  w_reload = CW'(VPP_RISE_CYCLES - 1);
      S_OVP_PULSE: w_reload = CW'(PULSE_CYCLES) * CW'(r_attempts) - CW'(1);
`endif
      default:     w_reload = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= w_reload;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      r_addr           <= 9'd0;
      r_target         <= 8'd0;
      r_read_value     <= 8'd0;
      r_sel            <= 3'd0;
      r_attempts       <= 4'd0;
      r_error          <= 1'b0;
      r_error_code     <= 2'd0;
      r_failed_bit     <= 3'd0;
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
      r_verify_pending <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr           <= target_address;
        r_target         <= target_data;
        r_error          <= 1'b0;
        r_error_code     <= 2'd0;
        r_failed_bit     <= 3'd0;
        r_sel            <= 3'd0;
        r_attempts       <= 4'd0;
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
        r_verify_pending <= 1'b0;
`endif
      end
      if (w_eval) begin
        r_read_value <= chip_data_port;
        if (w_err_set) begin
          r_error      <= 1'b1;
          r_error_code <= w_err_code;
          r_failed_bit <= w_err_bit;
        end
        if (w_next == S_VPP_ON || (w_next == S_ERROR && w_err_code == 2'd2)) begin
          r_sel      <= w_sel;
          r_attempts <= (w_next == S_VPP_ON) ? w_attempts_eff + 4'd1 : w_attempts_eff;
        end
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
        r_verify_pending <= (w_next == S_VPP_ON);
`endif
      end
    end
  end

  // Drive outputs straight from state so reset removes programming current immediately
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
  assign w_pulsing  = (r_state == S_PULSE) || (r_state == S_OVP_PULSE);
  assign vpp_enable = (r_state == S_VPP_ON) || (r_state == S_OVP_RISE) || w_pulsing;
`else
  assign w_pulsing  = (r_state == S_PULSE);
  assign vpp_enable = (r_state == S_VPP_ON) || w_pulsing;
`endif
  assign w_active          = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign program_bit_port  = w_pulsing ? (8'd1 << r_sel) : 8'd0;
  assign chip_select       = w_active;
  assign busy              = w_active;
  assign done              = (r_state == S_DONE);
  assign chip_address_port = r_addr;
  assign error             = r_error;
  assign error_code        = r_error_code;
  assign failed_bit        = r_failed_bit;
  assign read_value        = r_read_value;
endmodule

// File: tb/tb_rom_chip_burner.sv
// tb/tb_rom_chip_burner.sv - self-checking bench for rom_chip_burner with a behavioural fuse-chip model
module tb_rom_chip_burner;
  localparam int S = 4, R = 3, V = 8, P = 16, RC = 8, MAXA = 8;
  localparam int PER_PULSE = V + P + RC + R;

  logic       clk = 1'b0;
  logic       reset_button = 1'b0;
  logic       start = 1'b0;
  logic [8:0] target_address = 9'd0;
  logic [7:0] target_data = 8'd0;
  logic [7:0] chip_data_port;
  logic [8:0] chip_address_port;
  logic       chip_select, vpp_enable, busy, done, error;
  logic [7:0] program_bit_port, read_value;
  logic [1:0] error_code;
  logic [2:0] failed_bit;

  rom_chip_burner dut (
    .clk(clk), .reset_button(reset_button), .start(start),
    .target_address(target_address), .target_data(target_data),
    .chip_data_port(chip_data_port), .chip_address_port(chip_address_port),
    .chip_select(chip_select), .vpp_enable(vpp_enable),
    .program_bit_port(program_bit_port), .busy(busy), .done(done),
    .error(error), .error_code(error_code), .failed_bit(failed_bit),
    .read_value(read_value)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: each fuse blows after m_need[b] completed pulses (0 = never blows)
  logic [7:0] m_init = 8'd0;
  logic [7:0] m_prog = 8'd0;
  int         m_need [8];
  int         m_cnt  [8];
  logic       clear_model = 1'b0;
  logic [8:0] exp_addr = 9'd0;
  int         addr_bad = 0;
  int         obs_bits[$];
  int         obs_widths[$];
  logic [7:0] prev_pbp = 8'd0;
  int         cur_w = 0;

  assign chip_data_port = m_init | m_prog;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    int bidx;
    if (clear_model) begin
      m_prog = 8'd0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      obs_bits.delete();
      obs_widths.delete();
      addr_bad = 0;
      cur_w = 0;
      prev_pbp = 8'd0;
    end else begin
      if (chip_select && chip_address_port !== exp_addr) addr_bad++;
      if (program_bit_port != 8'd0) begin
        check("pulse_onehot", $countones(program_bit_port), 1);
        check("pulse_needs_vpp", vpp_enable, 1);
        if (prev_pbp == 8'd0) begin
          bidx = 0;
          for (int i = 0; i < 8; i++) if (program_bit_port[i]) bidx = i;
          obs_bits.push_back(bidx);
          cur_w = 0;
        end
        cur_w++;
      end else if (prev_pbp != 8'd0) begin
        obs_widths.push_back(cur_w);
        bidx = obs_bits[$];
        m_cnt[bidx]++;
        if (m_cnt[bidx] == m_need[bidx]) m_prog[bidx] = 1'b1;
      end
      prev_pbp = program_bit_port;
    end
  end

  // Reference outcome computed from the programming rules, not the FSM
  logic       e_err;
  logic [1:0] e_code;
  logic [2:0] e_fbit;
  logic [7:0] e_rv;
  int         e_cycles;
  int         e_bits[$];
  int         e_widths[$];

  task automatic model(input logic [7:0] init, input logic [7:0] tgt);
    logic [7:0] img;
    int n;
    img = init;
    e_bits.delete(); e_widths.delete();
    e_err = 1'b0; e_code = 2'd0; e_fbit = 3'd0; e_cycles = S + R;
    if ((init & ~tgt) != 8'd0) begin
      e_err = 1'b1; e_code = 2'd1;
      for (int b = 7; b >= 0; b--) if (init[b] && !tgt[b]) e_fbit = 3'(b);
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (tgt[b] && !img[b] && !e_err) begin
          n = (m_need[b] >= 1 && m_need[b] <= MAXA) ? m_need[b] : MAXA;
          for (int k = 0; k < n; k++) begin e_bits.push_back(b); e_widths.push_back(P); end
          e_cycles += n * PER_PULSE;
          if (m_need[b] < 1 || m_need[b] > MAXA) begin
            e_err = 1'b1; e_code = 2'd2; e_fbit = 3'(b);
          end else begin
            img[b] = 1'b1;
`ifdef ROM_CHIP_BURNER_OVERPROGRAM_EN
            e_bits.push_back(b); e_widths.push_back(P * n);
            e_cycles += V + P * n + RC + R;
`endif
          end
        end
      end
    end
    e_rv = img;
  endtask

  task automatic clear_chip();
    clear_model = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_model = 1'b0;
  endtask

  task automatic run_op(input logic [8:0] addr, input logic [7:0] tgt, input bit poke, input string name);
    int t0, tend, nb;
    bit seen;
    model(m_init, tgt);
    exp_addr = addr;
    clear_chip();
    target_address = addr; target_data = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check({name, "_busy_on_accept"}, busy, 1);
    seen = 1'b0; tend = -1;
    for (int i = 0; i < 6000; i++) begin
      if (done || (error && !busy)) begin seen = 1'b1; tend = cyc - t0; break; end
      if (poke) begin
        start = (i == 20);
        if (i == 20) begin target_address = ~addr; target_data = ~tgt; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_finished"}, seen, 1);
    check({name, "_cycles"}, tend, e_cycles);
    check({name, "_done"}, done, !e_err);
    check({name, "_error"}, error, e_err);
    check({name, "_error_code"}, error_code, e_code);
    if (e_err) check({name, "_failed_bit"}, failed_bit, e_fbit);
    check({name, "_read_value"}, read_value, e_rv);
    check({name, "_pulse_count"}, obs_bits.size(), e_bits.size());
    nb = (obs_bits.size() < e_bits.size()) ? obs_bits.size() : e_bits.size();
    for (int k = 0; k < nb; k++) begin
      check({name, "_pulse_bit"}, obs_bits[k], e_bits[k]);
      check({name, "_pulse_width"}, obs_widths[k], e_widths[k]);
    end
    check({name, "_address_stable"}, addr_bad, 0);
    @(negedge clk);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_error_sticky"}, error, e_err);
  endtask

  task automatic set_need(input int n);
    foreach (m_need[i]) m_need[i] = n;
  endtask

  initial begin : stim
    int cnt;
    logic [7:0] tgt;
    set_need(1);
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_vpp", vpp_enable, 0);
    check("reset_pbp", program_bit_port, 0);
    check("reset_cs", chip_select, 0);
    check("reset_addr", chip_address_port, 0);
    check("reset_code", error_code, 0);
    check("reset_rv", read_value, 0);
    reset_button = 1'b1;
    @(negedge clk);

    // Reset during the 5th cycle of a programming pulse
    m_init = 8'h00; set_need(1); exp_addr = 9'h0F0; clear_chip();
    target_address = 9'h0F0; target_data = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (program_bit_port != 8'd0) cnt++;
      if (cnt == 5) break;
    end
    check("rst_reached_pulse", cnt, 5);
    #2 reset_button = 1'b0;
    #1;
    check("rst_async_vpp", vpp_enable, 0);
    check("rst_async_pbp", program_bit_port, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_cs", chip_select, 0);
    @(negedge clk);
    reset_button = 1'b1;
    @(negedge clk);

    m_init = 8'h00; set_need(1);
    run_op(9'h1A5, 8'h81, 1'b0, "blank_81");
    m_init = 8'h00; set_need(1); m_need[4] = 3;
    run_op(9'h033, 8'h10, 1'b0, "three_pulse_b4");
    m_init = 8'h00; set_need(1); m_need[2] = 0;
    run_op(9'h100, 8'h04, 1'b0, "stuck_b2");
    m_init = 8'h21; set_need(1);
    run_op(9'h011, 8'h20, 1'b0, "irreversible");
    m_init = 8'h5A; set_need(1);
    run_op(9'h0AA, 8'h5A, 1'b0, "already_equal");
    m_init = 8'h00; set_need(1);
    run_op(9'h1FF, 8'hFF, 1'b1, "ff_with_poke");

    for (int r = 0; r < 10; r++) begin
      tgt = 8'($urandom);
      m_init = (r % 4 == 3) ? 8'($urandom) : (tgt & 8'($urandom));
      foreach (m_need[i]) m_need[i] = $urandom_range(1, 3);
      if (r % 5 == 4) m_need[$urandom_range(0, 7)] = (r == 4) ? 0 : MAXA + 1;
      run_op(9'($urandom), tgt, 1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
